gshare_pht: RTL

16-entry gshare pattern-history table for the fetch stage. Holds one 2-bit saturating counter per entry and a 4-bit global history register (GHR). Each cycle it drives the 16-bit taken-prediction vector and the 4-bit entry select to the downstream 16:1 single-bit selector, which produces the final taken/not-taken bit for the fetched branch. It also accepts branch-resolution updates from execute and supports a sweeping flush.

---
 rtl/gshare_pht.sv | 79 +++++++
 1 files changed

// File: rtl/gshare_pht.sv
// 16-entry gshare pattern-history table: 2-bit saturating counters plus a 4-bit global
// history, with a single update port and a one-entry-per-cycle flush sweep.
module gshare_pht #(
    parameter logic [1:0] CTR_INIT = 2'b01,
    parameter bit         HIST_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  fetch_idx,
    output logic [3:0]  pred_sel,
    output logic [15:0] pred_vec,
    input  logic        upd_valid,
    input  logic [3:0]  upd_idx,
    input  logic        upd_taken,
    input  logic        flush,
    output logic        busy
);

    typedef enum logic {StIdle, StFlush} state_e;

    state_e           state_q, state_d;
    logic [15:0][1:0] ctr_q, ctr_d;
    logic [3:0]       ghr_q, ghr_d;
    logic [3:0]       ptr_q, ptr_d;

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        ghr_d   = ghr_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                // Flush takes priority; a coincident update is dropped entirely.
                if (flush) begin
                    state_d = StFlush;
                    ptr_d   = 4'd0;
                    ghr_d   = 4'd0;
                end else if (upd_valid) begin
                    if (upd_taken) begin
                        if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'b01;
                    end else begin
                        if (ctr_q[upd_idx] != 2'b00) ctr_d[upd_idx] = ctr_q[upd_idx] - 2'b01;
                    end
                    ghr_d = {ghr_q[2:0], upd_taken};
                end
            end
            StFlush: begin
                ctr_d[ptr_q] = CTR_INIT;
                ptr_d        = ptr_q + 4'd1;
                if (ptr_q == 4'd15) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ctr_q   <= {16{CTR_INIT}};
            ghr_q   <= 4'd0;
            ptr_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            ghr_q   <= ghr_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        busy     = (state_q == StFlush);
        pred_sel = HIST_EN ? (fetch_idx ^ ghr_q) : fetch_idx;
        pred_vec = 16'h0000;
        if (!busy) begin
            for (int i = 0; i < 16; i++) pred_vec[i] = ctr_q[i][1];
        end
    end

endmodule
